hazard_ctrl_unit: RTL and testbench

- Parametrised next-generation hazard controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB latches).
- Replaces purely combinational stall/flush logic with an FSM that supports:
  - multi-cycle load-use bubbles
  - a configurable branch-resolution stage
  - memory-wait freezing
  - sticky halt
  - saturating stall/flush performance counters
- Drives enable/flush of every pipeline latch plus the PC enable.

---
 rtl/hazard_ctrl_unit.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch redirect flush, memory-wait
// freeze, sticky halt and saturating stall/flush counters for a 5-stage pipeline.
module hazard_ctrl_unit #(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned LU_STALL_CYC = 1,
  parameter int unsigned BR_STAGE     = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rt,
  input  logic             de_memread,
  input  logic [REG_W-1:0] de_wsel,
  input  logic             redirect,
  input  logic             halt,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             em_flush,
  output logic             mw_flush,
  output logic             lu_active,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned BCNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RUN, LU_STALL, HALTED} state_t;

  state_t             state, state_nx;
  logic [BCNT_W-1:0]  bcnt, bcnt_nx;
  logic               lu_hit;
  logic               mem_wait;
  logic               redir_acc;
  logic               stall_inc;

  assign lu_hit = de_memread && (de_wsel != '0) &&
                  ((de_wsel == fd_rs) || (fd_uses_rt && (de_wsel == fd_rt)));
  assign mem_wait = dmem_req && !dhit;

  // Prioritised output decode and next-state selection
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    mw_en     = 1'b1;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    em_flush  = 1'b0;
    mw_flush  = 1'b0;
    lu_active = 1'b0;
    state_nx  = state;
    bcnt_nx   = bcnt;
    redir_acc = 1'b0;

    if (!nRST || state == HALTED || mem_wait) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      em_en = 1'b0;
      mw_en = 1'b0;
    end else if (redirect) begin
      fd_flush  = 1'b1;
      de_flush  = 1'b1;
      em_flush  = (BR_STAGE == 3);
      state_nx  = RUN;
      bcnt_nx   = '0;
      redir_acc = 1'b1;
    end else if (state == LU_STALL || lu_hit) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_flush  = 1'b1;
      lu_active = 1'b1;
      if (state == LU_STALL) begin
        bcnt_nx  = bcnt - BCNT_W'(1);
        state_nx = (bcnt == BCNT_W'(1)) ? RUN : LU_STALL;
      end else if (LU_STALL_CYC > 1) begin
        bcnt_nx  = BCNT_W'(LU_STALL_CYC - 1);
        state_nx = LU_STALL;
      end
    end else if (!ihit) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
    end

    // Halt wins over whatever the cycle decided; only reset leaves HALTED
    if (nRST && state != HALTED && halt) begin
      state_nx = HALTED;
    end
  end

  assign stall_inc = (state != HALTED) && !pc_en;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      bcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
      if (stall_inc && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redir_acc && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: two parameterisations driven in lockstep
// against a cycle model of the hazard rules.
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       nrst;
  logic       ihit, dmem_req, dhit, fd_uses_rt, de_memread, redirect, halt;
  logic [4:0] fd_rs, fd_rt, de_wsel;

  logic pc_en0, fd_en0, de_en0, em_en0, mw_en0, fd_flush0, de_flush0, em_flush0, mw_flush0, lu_active0;
  logic pc_en1, fd_en1, de_en1, em_en1, mw_en1, fd_flush1, de_flush1, em_flush1, mw_flush1, lu_active1;
  logic [3:0]  stall_cnt0, flush_cnt0;
  logic [31:0] stall_cnt1, flush_cnt1;

  // u0: single bubble, EX redirect, 4-bit counters; u1: three bubbles, MEM redirect
  hazard_ctrl_unit #(.REG_W(5), .LU_STALL_CYC(1), .BR_STAGE(2), .CNT_W(4)) u0 (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt), .de_memread(de_memread),
    .de_wsel(de_wsel), .redirect(redirect), .halt(halt),
    .pc_en(pc_en0), .fd_en(fd_en0), .de_en(de_en0), .em_en(em_en0), .mw_en(mw_en0),
    .fd_flush(fd_flush0), .de_flush(de_flush0), .em_flush(em_flush0), .mw_flush(mw_flush0),
    .lu_active(lu_active0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  hazard_ctrl_unit #(.REG_W(5), .LU_STALL_CYC(3), .BR_STAGE(3), .CNT_W(32)) u1 (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt), .de_memread(de_memread),
    .de_wsel(de_wsel), .redirect(redirect), .halt(halt),
    .pc_en(pc_en1), .fd_en(fd_en1), .de_en(de_en1), .em_en(em_en1), .mw_en(mw_en1),
    .fd_flush(fd_flush1), .de_flush(de_flush1), .em_flush(em_flush1), .mw_flush(mw_flush1),
    .lu_active(lu_active1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  logic [9:0] got0, got1;
  assign got0 = {pc_en0, fd_en0, de_en0, em_en0, mw_en0, fd_flush0, de_flush0, em_flush0, mw_flush0, lu_active0};
  assign got1 = {pc_en1, fd_en1, de_en1, em_en1, mw_en1, fd_flush1, de_flush1, em_flush1, mw_flush1, lu_active1};

  typedef struct packed {
    logic [9:0]  o0;
    logic [9:0]  o1;
    logic [31:0] s0;
    logic [31:0] f0;
    logic [31:0] s1;
    logic [31:0] f1;
  } exp_t;

  exp_t sb[$];

  int          checks = 0;
  int          errors = 0;
  int          lu_p[2] = '{1, 3};
  int          br_p[2] = '{2, 3};
  logic [31:0] cmax[2] = '{32'd15, 32'hFFFF_FFFF};
  int          m_left[2];
  bit          m_halted[2];
  logic [31:0] m_scnt[2];
  logic [31:0] m_fcnt[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hz();
    return de_memread && de_wsel != 5'd0 &&
           (de_wsel == fd_rs || (fd_uses_rt && de_wsel == fd_rt));
  endfunction

  // Expected {pc,fd,de,em,mw en, fd,de,em,mw flush, lu_active}
  function automatic logic [9:0] model_out(input int k);
    if (!nrst || m_halted[k] || (dmem_req && !dhit)) return 10'b0;
    if (redirect) return {5'b11111, 2'b11, (br_p[k] == 3) ? 1'b1 : 1'b0, 2'b00};
    if (m_left[k] > 0 || hz()) return 10'b00111_01001;
    if (!ihit) return 10'b01111_10000;
    return 10'b11111_00000;
  endfunction

  task automatic model_reset(input int k);
    m_left[k]   = 0;
    m_halted[k] = 1'b0;
    m_scnt[k]   = '0;
    m_fcnt[k]   = '0;
  endtask

  task automatic model_adv(input int k, input logic [9:0] o);
    if (!nrst) begin
      model_reset(k);
      return;
    end
    if (m_halted[k]) return;
    if (!o[9] && m_scnt[k] != cmax[k]) m_scnt[k] = m_scnt[k] + 1;
    if (!(dmem_req && !dhit)) begin
      if (redirect) begin
        if (m_fcnt[k] != cmax[k]) m_fcnt[k] = m_fcnt[k] + 1;
        m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
      end else if (hz()) begin
        m_left[k] = lu_p[k] - 1;
      end
    end
    if (halt) m_halted[k] = 1'b1;
  endtask

  task automatic idle();
    ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b0; fd_uses_rt = 1'b0;
    de_memread = 1'b0; redirect = 1'b0; halt = 1'b0;
    fd_rs = 5'd1; fd_rt = 5'd2; de_wsel = 5'd3;
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge
  task automatic step();
    exp_t e, p;
    if (!nrst) begin
      model_reset(0);
      model_reset(1);
    end
    e.o0 = model_out(0);
    e.o1 = model_out(1);
    e.s0 = m_scnt[0];
    e.f0 = m_fcnt[0];
    e.s1 = m_scnt[1];
    e.f1 = m_fcnt[1];
    sb.push_back(e);
    #2;
    p = sb.pop_front();
    chk("outs_u0", 32'(got0), 32'(p.o0));
    chk("outs_u1", 32'(got1), 32'(p.o1));
    chk("stall_cnt_u0", 32'(stall_cnt0), p.s0);
    chk("flush_cnt_u0", 32'(flush_cnt0), p.f0);
    chk("stall_cnt_u1", stall_cnt1, p.s1);
    chk("flush_cnt_u1", flush_cnt1, p.f1);
    @(posedge clk);
    #1;
    model_adv(0, p.o0);
    model_adv(1, p.o1);
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    idle();
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    #1;
    chk("rst_pc_en", 32'(pc_en0), 32'd0);
    chk("rst_fd_en", 32'(fd_en1), 32'd0);
    step();
    step();
    nrst = 1'b1;
    step();

    // load-use hazard held for one cycle
    de_memread = 1'b1; de_wsel = 5'd5; fd_rs = 5'd5;
    #1;
    chk("lu_pc_en", 32'(pc_en0), 32'd0);
    chk("lu_de_flush", 32'(de_flush0), 32'd1);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    #1;
    chk("lu1_stall_cnt", 32'(stall_cnt0), 32'd1);
    chk("lu3_stall_cnt", stall_cnt1, 32'd3);

    // redirect during the second bubble of a three-cycle stall
    de_memread = 1'b1; de_wsel = 5'd5; fd_rs = 5'd5;
    step();
    idle();
    redirect = 1'b1;
    #1;
    chk("br3_em_flush", 32'(em_flush1), 32'd1);
    chk("br2_em_flush", 32'(em_flush0), 32'd0);
    chk("br_pc_en", 32'(pc_en1), 32'd1);
    step();
    idle();
    step();
    #1;
    chk("br_flush_cnt", flush_cnt1, 32'd1);

    // memory wait freezes a pending redirect
    redirect = 1'b1; dmem_req = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 4; i++) step();
    dhit = 1'b1;
    #1;
    chk("mw_release_flush", 32'(fd_flush1), 32'd1);
    step();
    idle();
    step();

    // load to r0 is never a hazard
    de_memread = 1'b1; de_wsel = 5'd0; fd_rs = 5'd0;
    #1;
    chk("r0_pc_en", 32'(pc_en1), 32'd1);
    step();
    idle();
    fd_uses_rt = 1'b0; de_memread = 1'b1; de_wsel = 5'd7; fd_rt = 5'd7;
    step();
    fd_uses_rt = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    // fetch misses saturate the narrow counter
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) step();
    idle();
    step();
    #1;
    chk("sat_stall_cnt", 32'(stall_cnt0), 32'd15);

    // sticky halt
    halt = 1'b1;
    step();
    idle();
    ihit = 1'b0; redirect = 1'b1;
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("halt_pc_en", 32'(pc_en1), 32'd0);
    chk("halt_fd_flush", 32'(fd_flush1), 32'd0);

    // reset clears counters and leaves halt
    idle();
    nrst = 1'b0;
    #1;
    chk("rst2_stall_cnt", stall_cnt1, 32'd0);
    chk("rst2_flush_cnt", flush_cnt1, 32'd0);
    step();
    nrst = 1'b1;
    step();

    for (int i = 0; i < 120; i++) begin
      ihit       = ($urandom_range(0, 3) != 0);
      dmem_req   = ($urandom_range(0, 3) == 0);
      dhit       = $urandom_range(0, 1) != 0;
      fd_rs      = 5'($urandom_range(0, 3));
      fd_rt      = 5'($urandom_range(0, 3));
      fd_uses_rt = $urandom_range(0, 1) != 0;
      de_memread = $urandom_range(0, 1) != 0;
      de_wsel    = 5'($urandom_range(0, 3));
      redirect   = ($urandom_range(0, 7) == 0);
      halt       = 1'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
